// File: rtl/instr_word_encoder_if.sv
// Request/write-port bundle for the instruction word encoder: symbolic request
// in, encoded memory write and fill status out.
interface instr_word_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    modport master (
        output clear, in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, full, err
    );

    modport slave (
        input  clear, in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_target,
        output in_ready, mem_we, mem_addr, mem_wdata, count, full, err
    );
endinterface

// File: rtl/instr_word_encoder.sv
// Packs symbolic MIPS requests into 32-bit words and writes them to consecutive
// instruction-memory addresses; one word per two cycles, in_ready low while writing or full.
module instr_word_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_word_encoder_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] BASE  = BASE_ADDR[ADDR_W-1:0];

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   cnt;
    logic [31:0]       word_q;
    logic              full_q;
    logic              err_q;

    logic              enc_legal;
    logic [31:0]       enc_word;

    // Opcode/funct map shared with the core's main decoder.
    always_comb begin
        enc_legal = 1'b1;
        enc_word  = 32'd0;
        case (bus.in_op)
            4'd0:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100000};
            4'd1:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100010};
            4'd2:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100100};
            4'd3:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100101};
            4'd4:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b100110};
            4'd5:  enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, 6'b101010};
            4'd6:  enc_word = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd7:  enc_word = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd8:  enc_word = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd9:  enc_word = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd10: enc_word = {6'b000101, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd11: enc_word = {6'b001111, 5'b00000, bus.in_rt, bus.in_imm};
            4'd12: enc_word = {6'b001101, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd13: enc_word = {6'b000010, bus.in_target};
            4'd14: enc_word = {6'b000011, bus.in_target};
            default: enc_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= BASE;
            cnt    <= '0;
            word_q <= 32'd0;
            full_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (bus.clear) begin
                // Restart wins over any pending write or request.
                state  <= IDLE;
                ptr    <= BASE;
                cnt    <= '0;
                full_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.in_valid) begin
                            if (enc_legal) begin
                                word_q <= enc_word;
                                state  <= WRITE;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    WRITE: begin
                        ptr <= ptr + 1'b1;
                        cnt <= cnt + 1'b1;
                        if (cnt + 1'b1 == DEPTH) begin
                            state  <= FULL;
                            full_q <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    FULL:    state <= FULL;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // clear gates the handshake and the write strobe within the same cycle.
    assign bus.in_ready  = (state == IDLE) && !bus.clear;
    assign bus.mem_we    = (state == WRITE) && !bus.clear;
    assign bus.mem_addr  = ptr;
    assign bus.mem_wdata = word_q;
    assign bus.count     = cnt;
    assign bus.full      = full_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_instr_word_encoder.sv
// Directed then random requests against a small MIPS encoding model with a
// 4-word memory whose base address forces pointer wrap through zero.
module tb_instr_word_encoder;
    localparam int ADDR_W    = 2;
    localparam int BASE_ADDR = 1;
    localparam int DEPTH     = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_word_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_word_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nchk = 0;
    int nerr = 0;
    int mcount = 0;
    bit mfull = 0;
    logic [31:0] last_word;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int op, input int rs, input int rt,
                                               input int rd, input int imm, input int tgt);
        longint w;
        int funct[6] = '{32, 34, 36, 37, 38, 42};
        w = 0;
        if (op <= 5) w = rs * 2**21 + rt * 2**16 + rd * 2**11 + funct[op];
        else if (op == 6)  w = 8  * 64'(2**26) + rs * 2**21 + rt * 2**16 + imm;
        else if (op == 7)  w = 35 * 64'(2**26) + rs * 2**21 + rt * 2**16 + imm;
        else if (op == 8)  w = 43 * 64'(2**26) + rs * 2**21 + rt * 2**16 + imm;
        else if (op == 9)  w = 4  * 64'(2**26) + rs * 2**21 + rt * 2**16 + imm;
        else if (op == 10) w = 5  * 64'(2**26) + rs * 2**21 + rt * 2**16 + imm;
        else if (op == 11) w = 15 * 64'(2**26) + rt * 2**16 + imm;
        else if (op == 12) w = 13 * 64'(2**26) + rs * 2**21 + rt * 2**16 + imm;
        else if (op == 13) w = 2  * 64'(2**26) + tgt;
        else if (op == 14) w = 3  * 64'(2**26) + tgt;
        return w[31:0];
    endfunction

    function automatic int model_addr();
        return (BASE_ADDR + mcount) % DEPTH;
    endfunction

    task automatic set_req(input int op, input int rs, input int rt, input int rd,
                           input int imm, input int tgt);
        bus.in_valid  = 1'b1;
        bus.in_op     = op[3:0];
        bus.in_rs     = rs[4:0];
        bus.in_rt     = rt[4:0];
        bus.in_rd     = rd[4:0];
        bus.in_imm    = imm[15:0];
        bus.in_target = tgt[25:0];
    endtask

    // Called at a falling edge with the DUT idle or full; returns at a falling edge.
    task automatic issue(input int op, input int rs, input int rt, input int rd,
                         input int imm, input int tgt);
        set_req(op, rs, rt, rd, imm, tgt);
        #1;
        chk("ready_at_req", bus.in_ready, mfull ? 1'b0 : 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (mfull) begin
            chk("full_no_we", bus.mem_we, 0);
            chk("full_count", bus.count, mcount);
            chk("full_flag", bus.full, 1);
        end else if (op == 15) begin
            chk("illegal_err", bus.err, 1);
            chk("illegal_no_we", bus.mem_we, 0);
            chk("illegal_ready", bus.in_ready, 1);
            @(negedge clk);
            chk("err_one_cycle", bus.err, 0);
            chk("illegal_count", bus.count, mcount);
            chk("illegal_no_we2", bus.mem_we, 0);
        end else begin
            chk("write_we", bus.mem_we, 1);
            chk("write_addr", bus.mem_addr, model_addr());
            chk("write_data", bus.mem_wdata, model_word(op, rs, rt, rd, imm, tgt));
            chk("write_ready_low", bus.in_ready, 0);
            chk("write_no_err", bus.err, 0);
            last_word = bus.mem_wdata;
            mcount++;
            if (mcount == DEPTH) mfull = 1;
            @(negedge clk);
            chk("post_count", bus.count, mcount);
            chk("post_full", bus.full, mfull);
            chk("post_we_low", bus.mem_we, 0);
        end
    endtask

    task automatic do_clear(input bit with_req);
        bus.clear = 1'b1;
        if (with_req) set_req(0, 1, 2, 3, 0, 0);
        #1;
        chk("clear_ready_low", bus.in_ready, 0);
        chk("clear_no_we", bus.mem_we, 0);
        @(negedge clk);
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        mcount = 0;
        mfull  = 0;
        chk("clear_count", bus.count, 0);
        chk("clear_full", bus.full, 0);
        chk("clear_addr", bus.mem_addr, BASE_ADDR);
        chk("clear_no_accept", bus.mem_we, 0);
        chk("clear_no_err", bus.err, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, bus.in_ready, 1);
        chk({tag, "_we"}, bus.mem_we, 0);
        chk({tag, "_addr"}, bus.mem_addr, BASE_ADDR);
        chk({tag, "_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_count"}, bus.count, 0);
        chk({tag, "_full"}, bus.full, 0);
        chk({tag, "_err"}, bus.err, 0);
    endtask

    initial begin
        bus.clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op = 4'd0;
        bus.in_rs = 5'd0;
        bus.in_rt = 5'd0;
        bus.in_rd = 5'd0;
        bus.in_imm = 16'd0;
        bus.in_target = 26'd0;
        last_word = 32'd0;

        @(negedge clk);
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(15, 7, 7, 7, 16'hffff, 0);
        issue(0, 1, 2, 3, 0, 0);
        chk("add_word", last_word, 32'h00221820);
        issue(6, 0, 8, 0, 16'h0005, 0);
        chk("addi_word", last_word, 32'h20080005);
        issue(7, 29, 4, 0, 16'h0008, 0);
        chk("lw_word", last_word, 32'h8FA40008);
        issue(13, 0, 0, 0, 0, 26'h0000010);
        chk("j_word", last_word, 32'h08000010);
        chk("filled", bus.full, 1);

        // Held request while full must be ignored for 10 cycles.
        set_req(0, 1, 2, 3, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_we", bus.mem_we, 0);
            chk("hold_ready", bus.in_ready, 0);
            chk("hold_count", bus.count, DEPTH);
        end
        bus.in_valid = 1'b0;
        do_clear(1'b1);

        issue(14, 0, 0, 0, 0, 26'h0000010);
        chk("jal_word", last_word, 32'h0C000010);
        chk("jal_addr_base", (BASE_ADDR + mcount - 1) % DEPTH, BASE_ADDR);

        // clear landing on a WRITE cycle suppresses the write.
        set_req(3, 4, 5, 6, 0, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("pre_clear_we", bus.mem_we, 1);
        do_clear(1'b0);
        issue(11, 9, 10, 0, 16'h1234, 0);
        chk("lui_word", last_word, 32'h3C0A1234);
        chk("after_clear_count", bus.count, 1);

        // rst between edges during WRITE.
        set_req(1, 2, 3, 4, 0, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("pre_rst_we", bus.mem_we, 1);
        #2 rst = 1'b1;
        #1 chk_reset_vals("midrst");
        #1 rst = 1'b0;
        mcount = 0;
        mfull  = 0;
        @(negedge clk);
        chk_reset_vals("postrst");

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_clear($urandom_range(0, 1) == 1);
            end else begin
                issue($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 31), $urandom_range(0, 65535),
                      $urandom_range(0, 32'h3ffffff));
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
